// File: rtl/prime_search_ctrl_if.sv
// Bus between prime_search_ctrl and its neighbours: start request and seed
// from the generator side, the four prime_tester flags, tester control,
// and the result/status presented to the serializer.
// Ports (master = controller view):
//   in : go, seed[31:0], tester_done[3:0], tester_is_prime[3:0]
//   out: tester_rst, tester_start, dividend[31:0], save, data_out[31:0],
//        busy, found, error, tries[15:0]
interface prime_search_ctrl_if;
    logic        go;
    logic [31:0] seed;
    logic [3:0]  tester_done;
    logic [3:0]  tester_is_prime;
    logic        tester_rst;
    logic        tester_start;
    logic [31:0] dividend;
    logic        save;
    logic [31:0] data_out;
    logic        busy;
    logic        found;
    logic        error;
    logic [15:0] tries;

    modport master (
        input  go, seed, tester_done, tester_is_prime,
        output tester_rst, tester_start, dividend, save, data_out,
               busy, found, error, tries
    );

    modport slave (
        output go, seed, tester_done, tester_is_prime,
        input  tester_rst, tester_start, dividend, save, data_out,
               busy, found, error, tries
    );
endinterface

// File: rtl/prime_search_ctrl.sv
// Prime search controller: on an accepted go it seeds a candidate from the
// generator, then clears/starts the four testers on each candidate in turn
// until a prime is found (strobed to the serializer with save), the try
// limit is reached, the candidate would wrap, or a tester times out.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - prime_search_ctrl_if.master (go/seed in, tester flags in,
//          tester control, result and status out; all outputs registered)
module prime_search_ctrl #(
    parameter int unsigned MAX_TRIES    = 1024,
    parameter int unsigned TEST_TIMEOUT = 65535,
    parameter int unsigned SAVE_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    prime_search_ctrl_if.master   bus
);

    localparam int unsigned CAND_W       = 32;
    localparam int unsigned TRIES_W      = 16;
    localparam int unsigned START_CYCLES = 3;
    localparam int unsigned STEP_MAX     = (SAVE_CYCLES > START_CYCLES) ? SAVE_CYCLES : START_CYCLES;
    localparam int unsigned STEP_W       = $clog2(STEP_MAX + 1);
    localparam int unsigned WAIT_W       = $clog2(TEST_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_EVAL,
        S_SAVE,
        S_DONE
    } state_t;

    state_t              state;
    logic [CAND_W-1:0]   cand;
    logic [STEP_W-1:0]   step_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                tester_rst_q;
    logic                tester_start_q;
    logic [CAND_W-1:0]   dividend_q;
    logic                save_q;
    logic [CAND_W-1:0]   data_out_q;
    logic                busy_q;
    logic                found_q;
    logic                error_q;
    logic [TRIES_W-1:0]  tries_q;

    logic [CAND_W-1:0]   first_cand_c;
    logic [TRIES_W-1:0]  tries_inc_c;

    // 0 and 1 are not primes; start such searches at 2.
    assign first_cand_c = (bus.seed < CAND_W'(2)) ? CAND_W'(2) : bus.seed;
    // Saturating try count.
    assign tries_inc_c  = (tries_q == '1) ? tries_q : tries_q + TRIES_W'(1);

    // Search sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cand           <= '0;
            step_cnt       <= '0;
            wait_cnt       <= '0;
            tester_rst_q   <= 1'b0;
            tester_start_q <= 1'b0;
            dividend_q     <= '0;
            save_q         <= 1'b0;
            data_out_q     <= '0;
            busy_q         <= 1'b0;
            found_q        <= 1'b0;
            error_q        <= 1'b0;
            tries_q        <= '0;
        end else begin
            case (state)
                // DONE behaves like IDLE so it can launch the next search.
                S_IDLE, S_DONE: begin
                    if (bus.go) begin
                        cand         <= first_cand_c;
                        dividend_q   <= first_cand_c;
                        found_q      <= 1'b0;
                        error_q      <= 1'b0;
                        tries_q      <= '0;
                        tester_rst_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    tester_rst_q   <= 1'b0;
                    tester_start_q <= 1'b1;
                    step_cnt       <= '0;
                    state          <= S_START;
                end

                S_START: begin
                    if (step_cnt == STEP_W'(START_CYCLES - 1)) begin
                        tester_start_q <= 1'b0;
                        wait_cnt       <= '0;
                        state          <= S_WAIT;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end

                // A finished test takes priority over a coincident timeout.
                S_WAIT: begin
                    if (bus.tester_done == 4'b1111) begin
                        state <= S_EVAL;
                    end else if (wait_cnt == WAIT_W'(TEST_TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_EVAL: begin
                    tries_q <= tries_inc_c;
                    if (&bus.tester_is_prime) begin
                        data_out_q <= cand;
                        found_q    <= 1'b1;
                        save_q     <= 1'b1;
                        step_cnt   <= '0;
                        state      <= S_SAVE;
                    end else if (cand == '1) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end else if (tries_inc_c == TRIES_W'(MAX_TRIES)) begin
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cand         <= cand + CAND_W'(1);
                        dividend_q   <= cand + CAND_W'(1);
                        tester_rst_q <= 1'b1;
                        state        <= S_CLEAR;
                    end
                end

                S_SAVE: begin
                    if (step_cnt == STEP_W'(SAVE_CYCLES - 1)) begin
                        save_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tester_rst   = tester_rst_q;
    assign bus.tester_start = tester_start_q;
    assign bus.dividend     = dividend_q;
    assign bus.save         = save_q;
    assign bus.data_out     = data_out_q;
    assign bus.busy         = busy_q;
    assign bus.found        = found_q;
    assign bus.error        = error_q;
    assign bus.tries        = tries_q;

endmodule

// File: doc/prime_search_ctrl.md
Name: prime_search_ctrl

Overview:
Control stage between number_generator and the four parallel prime_tester instances, and upstream of the serializer. On a go pulse it captures the generator value as a seed. It then walks candidates upward from the seed, running one prime test per candidate, until a prime is found or the search limit is reached. A found prime is presented to the serializer with a timed save strobe.

Parameters:
MAX_TRIES, 1024, maximum candidates tested per search before giving up
TEST_TIMEOUT, 65535, maximum clocks spent in WAIT for one candidate before aborting
SAVE_CYCLES, 4, clocks save is held high; serializer needs one clock per byte of a 32-bit word

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
go  in  1  single-cycle start pulse (from edge_detector_rising); ignored unless IDLE
seed  in  32  number_generator value, sampled on the accepted go
tester_done  in  4  done flags of prime_tester 0..3
tester_is_prime  in  4  is_prime flags of prime_tester 0..3
tester_rst  out  1  one-clock clear pulse to all four testers
tester_start  out  1  start level to testers
dividend  out  32  current candidate driven to all testers
save  out  1  serializer save strobe
data_out  out  32  prime result to serializer data_in
busy  out  1  high in every state except IDLE and DONE
found  out  1  last search ended with a prime
error  out  1  last search ended by timeout or overflow
tries  out  16  candidates tested in current/last search

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0, including dividend, data_out and tries.
- IDLE: on go=1 load cand = (seed < 2) ? 2 : seed; clear found, error and tries; go to CLEAR. A go arriving in any other state is dropped.
- CLEAR (1 clk): tester_rst=1, dividend=cand; go to START.
- START (3 clks): tester_start=1 and dividend held; then go to WAIT with tester_start=0.
- WAIT: stays until tester_done==4'b1111. A per-candidate counter increments every clock in WAIT; reaching TEST_TIMEOUT sets error=1 and goes to DONE.
- EVAL (1 clk): tries increments.
  - If &tester_is_prime: data_out=cand, found=1, go to SAVE.
  - Else if cand==32'hFFFFFFFF: error=1, go to DONE (no wrap to 0).
  - Else if tries (after increment)==MAX_TRIES: go to DONE with found=0 and error=0.
  - Else: cand=cand+1, go to CLEAR.
- SAVE: save=1 for exactly SAVE_CYCLES clocks with data_out stable, then DONE.
- DONE: busy=0; found, error, data_out and tries hold until the next accepted go. go in DONE behaves as in IDLE, so DONE is the next search's starting point.
- Latency per composite candidate: 1 + 3 + tester latency + 1 clocks. dividend changes only in CLEAR.
- Arithmetic and saturation: 32-bit unsigned; tries saturates at 16'hFFFF.
- Mid-search reset: all activity stops immediately; no partial save is emitted after rst.
- Asserting go and rst together: rst wins.

Test Plan:
- Bench tester model (done after 10 clks, is_prime from a reference primality function), seed=24, go pulse -> candidates 24,25,26,27,28,29 tested; data_out=29, found=1, tries=6, save high exactly 4 clks.
- seed=0 -> first dividend=2; result 2, tries=1.
- seed=32'hFFFFFFFF with model reporting composite -> error=1, found=0, tries=1, save never asserted.
- MAX_TRIES=3, seed=24 -> DONE after candidates 24..26; found=0, error=0, tries=3.
- Model never raises done, TEST_TIMEOUT=50 -> error=1 exactly 50 clks after entering WAIT; busy drops.
- go pulses while busy are ignored. rst asserted mid-WAIT with seed=90 -> all outputs 0 at once, state IDLE; next go restarts cleanly and finds 97.
